// File: rtl/decimal_input_entry.sv
// decimal_input_entry: keys a signed 32-bit operand one decimal digit per button press,
// commits it to `value`, and holds it until the IO stage consumes it.
// Ports: button_clock/reset (sync, active-high); digit/op/io_request per-press controls;
// value/ready committed operand; entry_mag/entry_neg/digit_count live entry preview; err reject flag.
module decimal_input_entry #(
  parameter int MAX_DIGITS = 10
) (
  input  logic        button_clock,
  input  logic        reset,
  input  logic [3:0]  digit,
  input  logic [1:0]  op,
  input  logic        io_request,
  output logic [31:0] value,
  output logic        ready,
  output logic [31:0] entry_mag,
  output logic        entry_neg,
  output logic [3:0]  digit_count,
  output logic        err
);

  typedef enum logic [1:0] {
    ST_ENTRY = 2'd0,
    ST_HELD  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [1:0]  OP_APPEND = 2'b00;
  localparam logic [1:0]  OP_SIGN   = 2'b01;
  localparam logic [1:0]  OP_BACK   = 2'b10;
  localparam logic [1:0]  OP_COMMIT = 2'b11;

  localparam logic [35:0] LIMIT_POS = 36'd2147483647;
  localparam logic [35:0] LIMIT_NEG = 36'd2147483648;
  localparam logic [3:0]  MAX_CNT   = 4'(MAX_DIGITS);

  state_t      state;
  state_t      state_next;

  logic [31:0] value_next;
  logic        ready_next;
  logic [31:0] mag_next;
  logic        neg_next;
  logic [3:0]  count_next;
  logic        err_next;

  // 36 bits so mag*10+digit cannot wrap before being compared to the limit.
  logic [35:0] candidate;
  logic [35:0] limit;
  logic        append_bad;
  logic        toggle_bad;
  logic        leading_zero;

  assign candidate    = ({4'd0, entry_mag} * 36'd10) + {32'd0, digit};
  assign limit        = entry_neg ? LIMIT_NEG : LIMIT_POS;
  assign append_bad   = (digit > 4'd9) || (digit_count == MAX_CNT) || (candidate > limit);
  // -2147483648 has no positive counterpart in 32 bits.
  assign toggle_bad   = entry_neg && ({4'd0, entry_mag} == LIMIT_NEG);
  assign leading_zero = (digit == 4'd0) && (entry_mag == 32'd0);

  // State and datapath registers; reset wins over every other input.
  always_ff @(posedge button_clock) begin
    if (reset) begin
      state       <= ST_ENTRY;
      value       <= 32'd0;
      ready       <= 1'b0;
      entry_mag   <= 32'd0;
      entry_neg   <= 1'b0;
      digit_count <= 4'd0;
      err         <= 1'b0;
    end else begin
      state       <= state_next;
      value       <= value_next;
      ready       <= ready_next;
      entry_mag   <= mag_next;
      entry_neg   <= neg_next;
      digit_count <= count_next;
      err         <= err_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_ENTRY: begin
        unique case (op)
          OP_APPEND: if (append_bad) state_next = ST_ERROR;
          OP_SIGN:   if (toggle_bad) state_next = ST_ERROR;
          OP_BACK:   state_next = ST_ENTRY;
          OP_COMMIT: state_next = ST_HELD;
          default:   state_next = ST_ENTRY;
        endcase
      end
      ST_HELD: begin
        if (io_request || (op == OP_BACK)) state_next = ST_ENTRY;
      end
      ST_ERROR: state_next = ST_ENTRY;
      default:  state_next = ST_ENTRY;
    endcase
  end

  // Next values for the registered outputs.
  always_comb begin
    value_next = value;
    ready_next = ready;
    mag_next   = entry_mag;
    neg_next   = entry_neg;
    count_next = digit_count;
    err_next   = 1'b0;
    unique case (state)
      ST_ENTRY: begin
        unique case (op)
          OP_APPEND: begin
            if (append_bad) begin
              err_next = 1'b1;
            end else begin
              mag_next = candidate[31:0];
              if (!leading_zero) count_next = digit_count + 4'd1;
            end
          end
          OP_SIGN: begin
            if (toggle_bad) err_next = 1'b1;
            else            neg_next = ~entry_neg;
          end
          OP_BACK: begin
            if (digit_count != 4'd0) begin
              mag_next   = entry_mag / 32'd10;
              count_next = digit_count - 4'd1;
            end
          end
          OP_COMMIT: begin
            // Negating zero yields zero, so negative zero commits as 0.
            value_next = entry_neg ? (32'd0 - entry_mag) : entry_mag;
            ready_next = 1'b1;
          end
          default: ;
        endcase
      end
      ST_HELD: begin
        if (io_request) begin
          value_next = 32'd0;
          ready_next = 1'b0;
          mag_next   = 32'd0;
          neg_next   = 1'b0;
          count_next = 4'd0;
        end else if (op == OP_BACK) begin
          ready_next = 1'b0;
        end
      end
      ST_ERROR: ;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_decimal_input_entry.sv
// tb_decimal_input_entry: directed scenarios plus random presses, each press checked
// against an arithmetic reference model of the entry block.
// Ports: none; drives decimal_input_entry and prints one summary line.
module tb_decimal_input_entry;

  logic        button_clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic [1:0]  op = 2'd0;
  logic        io_request = 1'b0;
  logic [31:0] value;
  logic        ready;
  logic [31:0] entry_mag;
  logic        entry_neg;
  logic [3:0]  digit_count;
  logic        err;

  decimal_input_entry #(.MAX_DIGITS(10)) dut (
    .button_clock(button_clock),
    .reset(reset),
    .digit(digit),
    .op(op),
    .io_request(io_request),
    .value(value),
    .ready(ready),
    .entry_mag(entry_mag),
    .entry_neg(entry_neg),
    .digit_count(digit_count),
    .err(err)
  );

  always #5 button_clock = ~button_clock;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: mode 0 keying, 1 committed, 2 after a rejected press.
  longint      m_mag = 0;
  bit          m_neg = 0;
  int          m_count = 0;
  logic [31:0] m_value = 0;
  bit          m_ready = 0;
  bit          m_err = 0;
  int          m_mode = 0;

  task automatic model_clear();
    m_mag = 0; m_neg = 0; m_count = 0; m_value = 0; m_ready = 0; m_err = 0; m_mode = 0;
  endtask

  task automatic model_step(input logic r, input logic [1:0] o, input logic [3:0] d, input logic io);
    longint cand;
    longint lim;
    if (r) begin
      model_clear();
    end else if (m_mode == 0) begin
      m_err = 0;
      case (o)
        2'd0: begin
          cand = m_mag * 10 + longint'(d);
          lim  = m_neg ? 64'd2147483648 : 64'd2147483647;
          if (d > 9 || m_count == 10 || cand > lim) begin
            m_err = 1; m_mode = 2;
          end else begin
            if (!(d == 0 && m_mag == 0)) m_count++;
            m_mag = cand;
          end
        end
        2'd1: begin
          if (m_neg && m_mag == 64'd2147483648) begin
            m_err = 1; m_mode = 2;
          end else begin
            m_neg = !m_neg;
          end
        end
        2'd2: begin
          if (m_count > 0) begin
            m_mag = m_mag / 10;
            m_count--;
          end
        end
        default: begin
          m_value = m_neg ? 32'(-m_mag) : 32'(m_mag);
          m_ready = 1; m_mode = 1;
        end
      endcase
    end else if (m_mode == 1) begin
      if (io) model_clear();
      else if (o == 2'd2) begin
        m_ready = 0; m_mode = 0;
      end
    end else begin
      m_err = 0; m_mode = 0;
    end
  endtask

  task automatic check_all();
    check("value", 64'(value), 64'(m_value));
    check("ready", 64'(ready), 64'(m_ready));
    check("entry_mag", 64'(entry_mag), 64'(m_mag));
    check("entry_neg", 64'(entry_neg), 64'(m_neg));
    check("digit_count", 64'(digit_count), 64'(m_count));
    check("err", 64'(err), 64'(m_err));
  endtask

  task automatic press(input logic r, input logic [1:0] o, input logic [3:0] d, input logic io);
    @(negedge button_clock);
    reset = r; op = o; digit = d; io_request = io;
    @(posedge button_clock);
    model_step(r, o, d, io);
    #1;
    check_all();
  endtask

  task automatic append(input int d);
    press(1'b0, 2'd0, 4'(d), 1'b0);
  endtask

  task automatic key_number(input longint n);
    int q[$];
    longint t;
    t = n;
    if (t == 0) q.push_front(0);
    while (t > 0) begin
      q.push_front(int'(t % 10));
      t = t / 10;
    end
    foreach (q[i]) append(q[i]);
  endtask

  initial begin
    // Reset with a press.
    press(1'b1, 2'd0, 4'd0, 1'b0);
    check("rst_value", 64'(value), 64'd0);
    check("rst_ready", 64'(ready), 64'd0);

    // 123 commit, then consume.
    key_number(123);
    press(1'b0, 2'd3, 4'd0, 1'b0);
    check("commit123", 64'(value), 64'h7B);
    check("commit123_rdy", 64'(ready), 64'd1);
    check("commit123_cnt", 64'(digit_count), 64'd3);
    press(1'b0, 2'd0, 4'd0, 1'b1);
    check("consume_rdy", 64'(ready), 64'd0);
    check("consume_val", 64'(value), 64'd0);

    // Leading zero, then -123.
    append(0);
    check("lead_zero_cnt", 64'(digit_count), 64'd0);
    key_number(123);
    press(1'b0, 2'd1, 4'd0, 1'b0);
    press(1'b0, 2'd3, 4'd0, 1'b0);
    check("commit_m123", 64'(value), 64'hFFFFFF85);
    press(1'b0, 2'd0, 4'd0, 1'b1);

    // Positive overflow, then the most negative value.
    key_number(214748364);
    append(8);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_mag", 64'(entry_mag), 64'd214748364);
    press(1'b0, 2'd0, 4'd5, 1'b0);           // recovery press, ignored
    check("recover_mag", 64'(entry_mag), 64'd214748364);
    press(1'b0, 2'd1, 4'd0, 1'b0);
    append(8);
    check("min_mag", 64'(entry_mag), 64'd2147483648);
    press(1'b0, 2'd1, 4'd0, 1'b0);           // cannot flip -2^31 positive
    check("min_toggle_err", 64'(err), 64'd1);
    check("min_toggle_neg", 64'(entry_neg), 64'd1);
    press(1'b0, 2'd0, 4'd0, 1'b0);
    press(1'b0, 2'd3, 4'd0, 1'b0);
    check("commit_min", 64'(value), 64'h80000000);
    press(1'b0, 2'd0, 4'd0, 1'b1);

    // Backspace behaviour.
    key_number(987);
    press(1'b0, 2'd2, 4'd0, 1'b0);
    press(1'b0, 2'd2, 4'd0, 1'b0);
    check("bs_mag", 64'(entry_mag), 64'd9);
    check("bs_cnt", 64'(digit_count), 64'd1);
    repeat (3) press(1'b0, 2'd2, 4'd0, 1'b0);
    check("bs_empty_mag", 64'(entry_mag), 64'd0);
    check("bs_empty_cnt", 64'(digit_count), 64'd0);
    check("bs_empty_err", 64'(err), 64'd0);
    append(12);
    check("illegal_digit_err", 64'(err), 64'd1);
    press(1'b0, 2'd0, 4'd0, 1'b0);

    // Un-commit and commit with io_request high.
    key_number(42);
    press(1'b0, 2'd3, 4'd0, 1'b0);
    press(1'b0, 2'd2, 4'd0, 1'b0);
    check("uncommit_rdy", 64'(ready), 64'd0);
    check("uncommit_mag", 64'(entry_mag), 64'd42);
    append(5);
    check("append_425", 64'(entry_mag), 64'd425);
    press(1'b0, 2'd3, 4'd0, 1'b1);
    check("commit_io_rdy", 64'(ready), 64'd1);
    check("commit_io_val", 64'(value), 64'd425);
    press(1'b0, 2'd0, 4'd0, 1'b1);
    check("late_consume", 64'(ready), 64'd0);

    // Reset mid-entry and while held.
    key_number(1234);
    check("mid_cnt", 64'(digit_count), 64'd4);
    press(1'b1, 2'd0, 4'd7, 1'b0);
    check("rst_mid_mag", 64'(entry_mag), 64'd0);
    key_number(77);
    press(1'b0, 2'd3, 4'd0, 1'b0);
    press(1'b1, 2'd0, 4'd0, 1'b0);
    check("rst_held_val", 64'(value), 64'd0);
    check("rst_held_rdy", 64'(ready), 64'd0);

    // Random presses, with some seeded near the limits.
    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [1:0] o;
      logic [3:0] d;
      if (i % 60 == 0) begin
        press(1'b1, 2'd0, 4'd0, 1'b0);
        if ($urandom_range(0, 1) == 1) press(1'b0, 2'd1, 4'd0, 1'b0);
        key_number(214748364);
      end
      sel = int'($urandom_range(0, 99));
      if (sel < 55)      o = 2'd0;
      else if (sel < 65) o = 2'd1;
      else if (sel < 80) o = 2'd2;
      else               o = 2'd3;
      d = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      press(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, o, d,
            ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
